rom_burst_reader: RTL and testbench

Initiator-side read engine for the GPU's synchronous ROM/RAM blocks (address in, data out after fixed pipeline latency). It accepts a burst command (start address, word count) and drives the memory address port one word per cycle. It captures each returned word after the configured read latency and streams the words out on a valid/ready interface. Backpressure is handled with a credit-limited output FIFO, so no word returned by the memory is ever dropped.

---
 rtl/rom_reader_pkg.sv | 15 +
 rtl/rom_reader_fifo.sv | 57 +++++
 rtl/rom_burst_reader.sv | 181 ++++++++++++++++++
 tb/tb_rom_burst_reader.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_reader_pkg.sv
// Shared types and helpers for the ROM burst reader.
package rom_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } reader_state_t;

  // Next word address, wrapping to 0 after the last valid word.
  function automatic int unsigned wrap_inc(input int unsigned addr, input int unsigned limit);
    return (addr + 1 >= limit) ? 0 : addr + 1;
  endfunction

endpackage

// File: rtl/rom_reader_fifo.sv
// Synchronous output FIFO holding captured memory words with their last flag.
module rom_reader_fifo #(
  parameter int DEPTH = 4,
  parameter type entry_t = logic [7:0],
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  entry_t           push_entry,
  input  logic             pop,
  output entry_t           head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t           store_q [DEPTH];
  entry_t           store_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    store_d  = store_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      store_d[wr_ptr_q] = push_entry;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        store_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      store_q  <= store_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = store_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/rom_burst_reader.sv
// Burst read engine: issues sequential addresses to a fixed-latency memory and
// streams the returned words through a credit-limited FIFO.
module rom_burst_reader
  import rom_reader_pkg::*;
#(
  parameter int WORD_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int NUM_WORDS    = 1 << ADDR_WIDTH,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH:0]   cmd_count,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_enable,
  input  logic [WORD_WIDTH-1:0] mem_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output reader_state_t         dbg_state
);

  // Handshakes: a transfer happens on a clock edge where valid && ready are
  // both high; valid never depends on ready, and the offered payload is held
  // unchanged while valid is high and ready is low.

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic                  last;
    logic [WORD_WIDTH-1:0] data;
  } fifo_entry_t;

  reader_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
  logic [CNT_W-1:0]      credit_q, credit_d;
  logic                  zero_done_q, zero_done_d;

  logic                  idle_ready;
  logic                  cmd_fire;
  logic                  issue;
  logic                  issue_last;
  logic                  push;
  logic                  push_last;
  logic                  pop;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  fifo_entry_t           push_entry;
  fifo_entry_t           head;

  // The idle cycle carrying a zero-length done does not take a new command.
  assign idle_ready = (state_q == IDLE) && !zero_done_q;
  assign cmd_fire   = cmd_valid && idle_ready;

  // credit_q counts words issued but not yet popped; a same-cycle pop frees a slot.
  assign issue      = (state_q == ISSUE) && ((credit_q - CNT_W'(pop)) < CNT_W'(FIFO_DEPTH));
  assign issue_last = remaining_q == (ADDR_WIDTH + 1)'(1);

  generate
    if (READ_LATENCY == 0) begin : g_lat0
      assign push      = issue;
      assign push_last = issue_last;
    end else begin : g_lat
      logic [READ_LATENCY-1:0] vld_q, vld_d;
      logic [READ_LATENCY-1:0] lst_q, lst_d;

      always_comb begin
        vld_d = (vld_q << 1) | READ_LATENCY'(issue);
        lst_d = (lst_q << 1) | READ_LATENCY'(issue && issue_last);
      end

      always_ff @(posedge clock) begin
        if (!reset_n) begin
          vld_q <= '0;
          lst_q <= '0;
        end else begin
          vld_q <= vld_d;
          lst_q <= lst_d;
        end
      end

      assign push      = vld_q[READ_LATENCY-1];
      assign push_last = lst_q[READ_LATENCY-1];
    end
  endgenerate

  assign push_entry = '{last: push_last, data: mem_q};

  rom_reader_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (fifo_entry_t)
  ) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (fifo_count)
  );

  assign fifo_empty = (fifo_count == '0);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    last_addr_d = last_addr_q;
    remaining_d = remaining_q;
    zero_done_d = 1'b0;
    credit_d    = credit_q + CNT_W'(issue) - CNT_W'(pop);
    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          if (cmd_count == '0) begin
            zero_done_d = 1'b1;
          end else begin
            state_d     = ISSUE;
            addr_d      = cmd_addr;
            remaining_d = cmd_count;
          end
        end
      end
      ISSUE: begin
        if (issue) begin
          addr_d      = ADDR_WIDTH'(wrap_inc(32'(addr_q), $unsigned(NUM_WORDS)));
          last_addr_d = addr_q;
          remaining_d = remaining_q - 1'b1;
          if (issue_last) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && head.last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      last_addr_q <= '0;
      remaining_q <= '0;
      credit_q    <= '0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      last_addr_q <= last_addr_d;
      remaining_q <= remaining_d;
      credit_q    <= credit_d;
      zero_done_q <= zero_done_d;
    end
  end

  // Every output is forced low while reset_n is held, even mid-burst.
  assign cmd_ready   = reset_n && idle_ready;
  assign mem_enable  = reset_n;
  assign mem_address = (!reset_n || state_q == IDLE) ? '0 : (issue ? addr_q : last_addr_q);
  assign out_valid   = reset_n && !fifo_empty;
  assign pop         = out_valid && out_ready;
  assign out_data    = reset_n ? head.data : '0;
  assign out_last    = out_valid && head.last;
  assign busy        = reset_n && (state_q != IDLE);
  assign done        = reset_n && (zero_done_q || (state_q == DRAIN && pop && head.last));
  assign dbg_state   = reset_n ? state_q : IDLE;

endmodule

// File: tb/tb_rom_burst_reader.sv
// Bench for rom_burst_reader: table-driven bursts on a 768-word latency-2 memory,
// hand-written reset sequence, and full sweeps at every read latency.
module tb_rom_burst_reader;
  import rom_reader_pkg::*;

  localparam int NW = 768;

  typedef struct {
    logic [9:0]  addr;
    logic [10:0] count;
    int          stall_at;
    int          stall_len;
    int          exp_first;
    int          exp_done;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset_n;
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- main DUT ----------------
  logic          cmd_valid, cmd_ready;
  logic [9:0]    cmd_addr;
  logic [10:0]   cmd_count;
  logic [9:0]    mem_address;
  logic          mem_enable;
  logic [31:0]   mem_q;
  logic          out_valid, out_ready, out_last, busy, done;
  logic [31:0]   out_data;
  reader_state_t dbg_state;

  rom_burst_reader #(
    .WORD_WIDTH(32), .ADDR_WIDTH(10), .NUM_WORDS(NW), .READ_LATENCY(2), .FIFO_DEPTH(4)
  ) dut (
    .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_count(cmd_count), .mem_address(mem_address),
    .mem_enable(mem_enable), .mem_q(mem_q), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  function automatic logic [31:0] word_at(input int a);
    return 32'(a) * 32'd3;
  endfunction

  function automatic logic [31:0] sweep_word(input logic [9:0] a);
    return {~a, 12'hA5C, a};
  endfunction

  // Latency-2 memory: registered address, registered data.
  logic [9:0]  mem_a_d1;
  logic [31:0] mem_q_r;
  always @(posedge clock) begin
    mem_a_d1 <= mem_address;
    mem_q_r  <= word_at(int'(mem_a_d1));
  end
  assign mem_q = mem_q_r;

  // ---------------- scoreboard ----------------
  int          n_vec = 0;
  int          n_fail = 0;
  logic [32:0] exp_q[$];
  logic        mon_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    logic        prev_stall;
    logic [32:0] prev_word;
    logic [32:0] e;
    prev_stall = 1'b0;
    prev_word  = '0;
    forever begin
      @(negedge clock);
      if (mon_on) begin
        if (prev_stall) begin
          chk("hold_valid", 64'(out_valid), 64'd1);
          chk("hold_word", 64'({out_last, out_data}), 64'(prev_word));
        end
        chk("addr_in_range", 64'(int'(mem_address) < NW), 64'd1);
        if (out_valid && out_ready) begin
          chk("word_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("out_word", 64'({out_last, out_data}), 64'(e));
            chk("done_with_last", 64'(done), 64'(e[32]));
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_word  = {out_last, out_data};
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_cmd(input vec_t v);
    int first_cyc, done_cyc, n;
    n = int'(v.count);
    @(posedge clock); #1;
    cmd_valid = 1'b1;
    cmd_addr  = v.addr;
    cmd_count = v.count;
    out_ready = 1'b1;
    @(negedge clock);
    chk("cmd_ready", 64'(cmd_ready), 64'd1);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({i == n - 1, word_at((int'(v.addr) + i) % NW)});
    end
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    first_cyc = -1;
    done_cyc  = -1;
    for (int cyc = 1; cyc <= 300 && done_cyc < 0; cyc++) begin
      if (cyc > 1) begin
        @(posedge clock); #1;
      end
      out_ready = !(v.stall_len > 0 && cyc >= v.stall_at && cyc < v.stall_at + v.stall_len);
      @(negedge clock);
      if (cyc == 1) chk("busy", 64'(busy), 64'(n != 0));
      if (out_valid && first_cyc < 0) first_cyc = cyc;
      if (done) done_cyc = cyc;
    end
    out_ready = 1'b1;
    chk("first_word_cycle", 64'(first_cyc), 64'(v.exp_first));
    chk("done_cycle", 64'(done_cyc), 64'(v.exp_done));
    chk("words_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_mem_address", 64'(mem_address), 64'd0);
    chk("rst_mem_enable", 64'(mem_enable), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(IDLE));
  endtask

  // ---------------- latency sweep: one DUT per READ_LATENCY ----------------
  for (genvar g = 0; g < 4; g++) begin : g_sweep
    logic          sw_rst_n, sw_cmd_valid, sw_cmd_ready, sw_mem_enable;
    logic [9:0]    sw_cmd_addr, sw_mem_address;
    logic [10:0]   sw_cmd_count;
    logic [31:0]   sw_mem_q, sw_out_data;
    logic          sw_out_valid, sw_out_ready, sw_out_last, sw_busy, sw_done;
    reader_state_t sw_state;
    logic [9:0]    a_pipe [4];
    logic [31:0]   sw_q[$];
    logic          fin = 1'b0;

    rom_burst_reader #(
      .WORD_WIDTH(32), .ADDR_WIDTH(10), .READ_LATENCY(g), .FIFO_DEPTH(4)
    ) u_dut (
      .clock(clock), .reset_n(sw_rst_n), .cmd_valid(sw_cmd_valid), .cmd_ready(sw_cmd_ready),
      .cmd_addr(sw_cmd_addr), .cmd_count(sw_cmd_count), .mem_address(sw_mem_address),
      .mem_enable(sw_mem_enable), .mem_q(sw_mem_q), .out_valid(sw_out_valid),
      .out_ready(sw_out_ready), .out_data(sw_out_data), .out_last(sw_out_last),
      .busy(sw_busy), .done(sw_done), .dbg_state(sw_state)
    );

    always @(posedge clock) begin
      a_pipe[0] <= sw_mem_address;
      for (int k = 1; k < 4; k++) a_pipe[k] <= a_pipe[k-1];
    end

    if (g == 0) begin : g_comb
      assign sw_mem_q = sweep_word(sw_mem_address);
    end else begin : g_reg
      assign sw_mem_q = sweep_word(a_pipe[g-1]);
    end

    initial begin
      logic [9:0]  start;
      logic [31:0] e;
      int          first_c, done_c;
      sw_rst_n = 1'b0; sw_cmd_valid = 1'b0; sw_cmd_addr = '0; sw_cmd_count = '0;
      sw_out_ready = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      sw_rst_n     = 1'b1;
      start        = 10'($urandom_range(0, 1023));
      sw_cmd_valid = 1'b1;
      sw_cmd_addr  = start;
      sw_cmd_count = 11'd1024;
      for (int i = 0; i < 1024; i++) sw_q.push_back(sweep_word(10'(int'(start) + i)));
      @(posedge clock); #1;
      sw_cmd_valid = 1'b0;
      first_c = -1;
      done_c  = -1;
      for (int cyc = 1; cyc <= 1200 && done_c < 0; cyc++) begin
        @(negedge clock);
        if (sw_out_valid) begin
          if (first_c < 0) first_c = cyc;
          chk("sweep_word_expected", 64'(sw_q.size() != 0), 64'd1);
          if (sw_q.size() != 0) begin
            e = sw_q.pop_front();
            chk("sweep_data", 64'(sw_out_data), 64'(e));
            chk("sweep_last", 64'(sw_out_last), 64'(sw_q.size() == 0));
          end
        end
        if (sw_done) done_c = cyc;
      end
      chk("sweep_first_cycle", 64'(first_c), 64'(g + 2));
      chk("sweep_done_cycle", 64'(done_c), 64'(g + 2 + 1023));
      chk("sweep_words_left", 64'(sw_q.size()), 64'd0);
      fin = 1'b1;
    end
  end

  // ---------------- main sequence ----------------
  vec_t vecs[8];
  vec_t post_rst;

  initial begin
    vecs[0] = '{addr: 10'd5,   count: 11'd4,  stall_at: 0, stall_len: 0,  exp_first: 4,  exp_done: 7};
    vecs[1] = '{addr: 10'd0,   count: 11'd1,  stall_at: 0, stall_len: 0,  exp_first: 4,  exp_done: 4};
    vecs[2] = '{addr: 10'd766, count: 11'd4,  stall_at: 0, stall_len: 0,  exp_first: 4,  exp_done: 7};
    vecs[3] = '{addr: 10'd767, count: 11'd1,  stall_at: 0, stall_len: 0,  exp_first: 4,  exp_done: 4};
    vecs[4] = '{addr: 10'd40,  count: 11'd0,  stall_at: 0, stall_len: 0,  exp_first: -1, exp_done: 1};
    vecs[5] = '{addr: 10'd100, count: 11'd8,  stall_at: 0, stall_len: 0,  exp_first: 4,  exp_done: 11};
    vecs[6] = '{addr: 10'd200, count: 11'd16, stall_at: 5, stall_len: 10, exp_first: 4,  exp_done: 29};
    vecs[7] = '{addr: 10'd760, count: 11'd16, stall_at: 0, stall_len: 0,  exp_first: 4,  exp_done: 19};
    post_rst = '{addr: 10'd10, count: 11'd3, stall_at: 0, stall_len: 0, exp_first: 4, exp_done: 6};

    reset_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_count = '0; out_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_reset_outputs();
    @(posedge clock); #1;
    reset_n = 1'b1;
    mon_on  = 1'b1;
    @(negedge clock);
    chk("ready_after_reset", 64'(cmd_ready), 64'd1);
    chk("mem_enable_run", 64'(mem_enable), 64'd1);

    foreach (vecs[i]) run_cmd(vecs[i]);

    // Reset while draining: nothing from the aborted burst may reappear.
    @(posedge clock); #1;
    cmd_valid = 1'b1; cmd_addr = 10'd300; cmd_count = 11'd8; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back({i == 7, word_at(300 + i)});
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    for (int n = 0; n < 20 && dbg_state != DRAIN; n++) @(negedge clock);
    chk("reached_drain", 64'(dbg_state), 64'(DRAIN));
    @(posedge clock); #1;
    reset_n = 1'b0;
    mon_on  = 1'b0;
    @(negedge clock);
    check_reset_outputs();
    @(posedge clock); #1;
    reset_n = 1'b1;
    exp_q.delete();
    mon_on  = 1'b1;
    @(negedge clock);
    chk("ready_after_mid_reset", 64'(cmd_ready), 64'd1);
    for (int n = 0; n < 6; n++) begin
      @(negedge clock);
      chk("no_stale_word", 64'(out_valid), 64'd0);
    end
    run_cmd(post_rst);

    for (int n = 0; n < 3000 && !(g_sweep[0].fin && g_sweep[1].fin && g_sweep[2].fin && g_sweep[3].fin); n++)
      @(negedge clock);
    chk("sweeps_finished",
        64'({g_sweep[3].fin, g_sweep[2].fin, g_sweep[1].fin, g_sweep[0].fin}), 64'hF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
